// File: rtl/sram_port_arbiter.sv
// Inst/data arbiter for one 64-bit single-ported SRAM with tagged read return.
// Optional perf counters enabled by defining ARB_PERF_CNT_EN.
module sram_port_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [7:0]  d_we,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        mem_en,
  output logic [7:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_i_stall,
  output logic [31:0] perf_d_wr
`endif
);

  logic [3:0]         starve_cnt;
  logic               starved;
  logic               rd_push;
  logic [MEM_LAT-1:0] tag_v;
  logic [MEM_LAT-1:0] tag_i;
  logic [MEM_LAT-1:0] tag_a;
  logic [31:0]        i_hold;
  logic [63:0]        d_hold;
  logic               unused;

  assign unused  = ^{i_addr[1:0], d_addr[2:0]};
  assign starved = (starve_cnt == 4'(STARVE_MAX));

  // Grants are gated by reset so every output reads 0 while held.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (reset) begin
      if (d_req && !(i_req && starved))
        d_gnt = 1'b1;
      else if (i_req)
        i_gnt = 1'b1;
    end
  end

  always_comb begin
    mem_en    = i_gnt | d_gnt;
    mem_wen   = d_gnt ? d_we : 8'h00;
    mem_addr  = 32'h0;
    mem_wdata = 64'h0;
    if (d_gnt) begin
      mem_addr  = {d_addr[31:3], 3'b000};
      mem_wdata = d_wdata;
    end else if (i_gnt) begin
      mem_addr  = {i_addr[31:3], 3'b000};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      starve_cnt <= 4'h0;
    else if (i_gnt || !i_req)
      starve_cnt <= 4'h0;
    else if (d_gnt && !starved)
      starve_cnt <= starve_cnt + 4'h1;
  end

  assign rd_push = i_gnt | (d_gnt && (d_we == 8'h00));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
      tag_i <= '0;
      tag_a <= '0;
    end else begin
      tag_v[0] <= rd_push;
      tag_i[0] <= i_gnt;
      tag_a[0] <= i_addr[2];
      for (int k = 1; k < MEM_LAT; k++) begin
        tag_v[k] <= tag_v[k-1];
        tag_i[k] <= tag_i[k-1];
        tag_a[k] <= tag_a[k-1];
      end
    end
  end

  assign i_rvalid = tag_v[MEM_LAT-1] & tag_i[MEM_LAT-1];
  assign d_rvalid = tag_v[MEM_LAT-1] & ~tag_i[MEM_LAT-1];

  // Memory data lands in the response cycle; pass it through, else hold.
  always_comb begin
    i_rdata = i_hold;
    d_rdata = d_hold;
    if (i_rvalid)
      i_rdata = tag_a[MEM_LAT-1] ? mem_rdata[63:32]
                                 : mem_rdata[31:0];
    if (d_rvalid)
      d_rdata = mem_rdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      i_hold <= 32'h0;
      d_hold <= 64'h0;
    end else begin
      i_hold <= i_rdata;
      d_hold <= d_rdata;
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_i_stall <= 32'h0;
      perf_d_wr    <= 32'h0;
    end else begin
      if (i_req && !i_gnt && perf_i_stall != 32'hFFFF_FFFF)
        perf_i_stall <= perf_i_stall + 32'h1;
      if (d_gnt && |d_we && perf_d_wr != 32'hFFFF_FFFF)
        perf_d_wr <= perf_d_wr + 32'h1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: u1 (MEM_LAT=1, STARVE_MAX=4),
// u3 (MEM_LAT=3, STARVE_MAX=8) share all inputs.
module tb_sram_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic [7:0]  d_we;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic [63:0] mem_rdata;

  logic        i_gnt1, i_rvalid1, d_gnt1, d_rvalid1, mem_en1;
  logic [31:0] i_rdata1, mem_addr1;
  logic [63:0] d_rdata1, mem_wdata1;
  logic [7:0]  mem_wen1;
  logic        i_gnt3, i_rvalid3, d_gnt3, d_rvalid3, mem_en3;
  logic [31:0] i_rdata3, mem_addr3;
  logic [63:0] d_rdata3, mem_wdata3;
  logic [7:0]  mem_wen3;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_i_stall1, perf_d_wr1;
  logic [31:0] perf_i_stall3, perf_d_wr3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  sram_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) u1 (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt1),
    .i_rvalid(i_rvalid1), .i_rdata(i_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt1),
    .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_wen(mem_wen1),
    .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_stall(perf_i_stall1), .perf_d_wr(perf_d_wr1)
`endif
  );

  sram_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(8)) u3 (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt3),
    .i_rvalid(i_rvalid3), .i_rdata(i_rdata3),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt3),
    .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_wen(mem_wen3),
    .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata)
`ifdef ARB_PERF_CNT_EN
    , .perf_i_stall(perf_i_stall3), .perf_d_wr(perf_d_wr3)
`endif
  );

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    i_req = 1'b0; i_addr = 32'h0;
    d_req = 1'b0; d_we = 8'h0;
    d_addr = 32'h0; d_wdata = 64'h0;
  endtask

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  // Inst request must stay put until granted (u1 grants are the reference).
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  always @(negedge clock) begin
    if (reset === 1'b1 && pend) begin
      checks++;
      if (!(i_req === 1'b1 && i_addr === pend_addr)) begin
        errors++;
        $display("FAIL i_req_stable got=%b/%h want=1/%h",
                 i_req, i_addr, pend_addr);
      end
    end
    pend      = (reset === 1'b1) && i_req && !i_gnt1;
    pend_addr = i_addr;
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic [7:0]  we;
    logic [31:0] da;
    logic [63:0] wd;
    logic        eig;
    logic        edg;
    logic        een;
    logic [7:0]  ewen;
    logic [31:0] eaddr;
    logic [63:0] ewd;
  } vec_t;

  vec_t tv [8];
  logic [63:0] rdv [3];

  initial begin
    tv[0] = '{1'b0, 32'h0, 1'b0, 8'h00, 32'h0, 64'h0,
              1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 64'h0};
    tv[1] = '{1'b1, 32'h1007, 1'b0, 8'h00, 32'h0, 64'h0,
              1'b1, 1'b0, 1'b1, 8'h00, 32'h1000, 64'h0};
    tv[2] = '{1'b0, 32'h0, 1'b1, 8'h00, 32'h200F, 64'h1234,
              1'b0, 1'b1, 1'b1, 8'h00, 32'h2008, 64'h1234};
    tv[3] = '{1'b0, 32'h0, 1'b1, 8'h0F, 32'h2008, 64'h55,
              1'b0, 1'b1, 1'b1, 8'h0F, 32'h2008, 64'h55};
    tv[4] = '{1'b1, 32'h40, 1'b1, 8'hFF, 32'h3004, 64'hDEAD,
              1'b0, 1'b1, 1'b1, 8'hFF, 32'h3000, 64'hDEAD};
    tv[5] = '{1'b1, 32'h40, 1'b0, 8'h00, 32'h0, 64'h0,
              1'b1, 1'b0, 1'b1, 8'h00, 32'h40, 64'h0};
    tv[6] = '{1'b1, 32'h1004, 1'b1, 8'h00, 32'h18, 64'h0,
              1'b0, 1'b1, 1'b1, 8'h00, 32'h18, 64'h0};
    tv[7] = '{1'b1, 32'h1004, 1'b0, 8'h00, 32'h0, 64'h0,
              1'b1, 1'b0, 1'b1, 8'h00, 32'h1000, 64'h0};

    reset = 1'b0;
    mem_rdata = 64'h0;
    idle_in();

    // Reset: outputs 0 even with a request present.
    drive_edge();
    i_req = 1'b1; i_addr = 32'h1000;
    @(negedge clock);
    chk("rst_i_gnt", 64'(i_gnt1), 64'h0);
    chk("rst_mem_en", 64'(mem_en1), 64'h0);
    chk("rst_mem_addr", 64'(mem_addr1), 64'h0);
    chk("rst_i_rvalid", 64'(i_rvalid1), 64'h0);
    chk("rst_d_rvalid", 64'(d_rvalid1), 64'h0);
    chk("rst_i_rdata", 64'(i_rdata1), 64'h0);
    drive_edge();
    idle_in();
    reset = 1'b1;

    for (int v = 0; v < 8; v++) begin
      drive_edge();
      i_req = tv[v].ir; i_addr = tv[v].ia;
      d_req = tv[v].dr; d_we = tv[v].we;
      d_addr = tv[v].da; d_wdata = tv[v].wd;
      @(negedge clock);
      chk($sformatf("v%0d_i_gnt", v), 64'(i_gnt1), 64'(tv[v].eig));
      chk($sformatf("v%0d_d_gnt", v), 64'(d_gnt1), 64'(tv[v].edg));
      chk($sformatf("v%0d_mem_en", v), 64'(mem_en1), 64'(tv[v].een));
      chk($sformatf("v%0d_mem_wen", v), 64'(mem_wen1), 64'(tv[v].ewen));
      chk($sformatf("v%0d_mem_addr", v), 64'(mem_addr1), 64'(tv[v].eaddr));
      chk($sformatf("v%0d_mem_wdata", v), mem_wdata1, tv[v].ewd);
    end
    drive_edge();
    idle_in();
    repeat (4) drive_edge();

    // Single inst read, latency 1, upper word, then hold.
    i_req = 1'b1; i_addr = 32'h1004;
    mem_rdata = 64'hAABBCCDD_11223344;
    @(negedge clock);
    chk("t1_i_gnt", 64'(i_gnt1), 64'h1);
    drive_edge();
    idle_in();
    @(negedge clock);
    chk("t1_i_rvalid", 64'(i_rvalid1), 64'h1);
    chk("t1_i_rdata", 64'(i_rdata1), 64'hAABBCCDD);
    drive_edge();
    mem_rdata = 64'h0;
    @(negedge clock);
    chk("t1_i_rvalid_off", 64'(i_rvalid1), 64'h0);
    chk("t1_i_rdata_hold", 64'(i_rdata1), 64'hAABBCCDD);
    repeat (3) drive_edge();

    // Data write: memory drive, never a response.
    d_req = 1'b1; d_we = 8'h0F;
    d_addr = 32'h2008; d_wdata = 64'h55;
    @(negedge clock);
    chk("t2_mem_en", 64'(mem_en1), 64'h1);
    chk("t2_mem_wen", 64'(mem_wen1), 64'h0F);
    chk("t2_mem_addr", 64'(mem_addr1), 64'h2008);
    drive_edge();
    idle_in();
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("t2_d_rvalid1_%0d", k), 64'(d_rvalid1), 64'h0);
      chk($sformatf("t2_d_rvalid3_%0d", k), 64'(d_rvalid3), 64'h0);
      drive_edge();
    end

    // Starvation: both held 10 cycles -> D,D,D,D,I,D,D,D,D,I on u1.
    for (int k = 0; k < 10; k++) begin
      i_req = 1'b1; i_addr = 32'h500;
      d_req = 1'b1; d_we = 8'h00; d_addr = 32'h600;
      @(negedge clock);
      chk($sformatf("t3_i_gnt_%0d", k), 64'(i_gnt1),
          64'((k == 4) || (k == 9)));
      chk($sformatf("t3_d_gnt_%0d", k), 64'(d_gnt1),
          64'(!((k == 4) || (k == 9))));
      drive_edge();
    end
    idle_in();
    repeat (5) drive_edge();

    // Back-to-back I,D,I reads on u3 (latency 3).
    rdv[0] = 64'h11111111_22222222;
    rdv[1] = 64'h33333333_44444444;
    rdv[2] = 64'h55555555_66666666;
    for (int k = 0; k < 7; k++) begin
      idle_in();
      mem_rdata = 64'h0;
      if (k == 0) begin i_req = 1'b1; i_addr = 32'h4; end
      if (k == 1) begin d_req = 1'b1; d_addr = 32'h10; end
      if (k == 2) begin i_req = 1'b1; i_addr = 32'h8; end
      if (k >= 3 && k <= 5) mem_rdata = rdv[k-3];
      @(negedge clock);
      if (k == 0) chk("t4_i_gnt", 64'(i_gnt3), 64'h1);
      if (k == 1) chk("t4_d_gnt", 64'(d_gnt3), 64'h1);
      chk($sformatf("t4_i_rvalid_%0d", k), 64'(i_rvalid3),
          64'((k == 3) || (k == 5)));
      chk($sformatf("t4_d_rvalid_%0d", k), 64'(d_rvalid3),
          64'(k == 4));
      if (k == 3) chk("t4_i_rdata0", 64'(i_rdata3), 64'h11111111);
      if (k == 4) chk("t4_d_rdata", d_rdata3, rdv[1]);
      if (k == 5) chk("t4_i_rdata1", 64'(i_rdata3), 64'h66666666);
      drive_edge();
    end
    idle_in();
    mem_rdata = 64'h0;
    repeat (2) drive_edge();

    // Reset one cycle after a read grant drops the read.
    i_req = 1'b1; i_addr = 32'h4;
    mem_rdata = 64'hFFFFFFFF_FFFFFFFF;
    @(negedge clock);
    chk("t5_i_gnt", 64'(i_gnt3), 64'h1);
    drive_edge();
    idle_in();
    #2 reset = 1'b0;
    #1;
    chk("t5_i_rvalid", 64'(i_rvalid3), 64'h0);
    chk("t5_d_rvalid", 64'(d_rvalid3), 64'h0);
    chk("t5_i_rdata", 64'(i_rdata3), 64'h0);
    chk("t5_d_rdata", d_rdata3, 64'h0);
    chk("t5_mem_en", 64'(mem_en3), 64'h0);
    drive_edge();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("t5_post_i_rv3_%0d", k), 64'(i_rvalid3), 64'h0);
      chk($sformatf("t5_post_d_rv3_%0d", k), 64'(d_rvalid3), 64'h0);
      drive_edge();
    end
    mem_rdata = 64'h0;

`ifdef ARB_PERF_CNT_EN
    // u3 (STARVE_MAX=8) keeps inst stalled behind 5 data writes.
    for (int k = 0; k < 5; k++) begin
      i_req = 1'b1; i_addr = 32'h700;
      d_req = 1'b1; d_we = 8'h01;
      d_addr = 32'h800; d_wdata = 64'h1;
      @(negedge clock);
      chk($sformatf("t6_d_gnt3_%0d", k), 64'(d_gnt3), 64'h1);
      drive_edge();
    end
    idle_in();
    @(negedge clock);
    chk("t6_perf_i_stall", 64'(perf_i_stall3), 64'd5);
    chk("t6_perf_d_wr", 64'(perf_d_wr3), 64'd5);
    drive_edge();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
